// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// One op in flight: IDLE accepts, EXEC lets the ALU settle, RESP holds the result until consumed.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             grant;
  logic             accept;
  logic             owner_ready;

  // Contention goes to prio; otherwise whoever is valid (defaults to 0 when nobody is).
  assign grant       = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign req0_ready  = (state_q == IDLE) & req0_valid & ~grant;
  assign req1_ready  = (state_q == IDLE) & req1_valid & grant;
  assign accept      = req0_ready | req1_ready;
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          a_d     = grant ? req1_a  : req0_a;
          b_d     = grant ? req1_b  : req0_b;
          op_d    = grant ? req1_op : req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_c;
        state_d = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Result data is gated so an idle response channel always reads zero.
  assign resp0_valid = (state_q == RESP) & ~owner_q;
  assign resp1_valid = (state_q == RESP) & owner_q;
  assign resp0_c     = resp0_valid ? res_q : '0;
  assign resp1_c     = resp1_valid ? res_q : '0;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance (A, B, ALUOp -> C) between two requesters, e.g. a datapath issue port and a debug/test port. Uses a round-robin grant with valid/ready handshakes on both request and response channels. Drives the ALU operands from registers and captures C into a registered result. One operation is in flight at a time; ALUOp is passed through to the ALU without being decoded.

Parameters:
WIDTH, 32, operand/result width (matches alu A/B/C)
OPW, 3, ALUOp width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  OPW  requester 0 ALUOp
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 consumes result
resp0_c  output  WIDTH  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
resp1_valid, resp1_ready, resp1_c  same as requester 0, for requester 1
alu_a  output  WIDTH  to alu.A
alu_b  output  WIDTH  to alu.B
alu_op  output  OPW  to alu.ALUOp
alu_c  input  WIDTH  from alu.C
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous, immediate) sets all of the following:
  - state=IDLE, prio=0 (requester 0 favoured).
  - alu_a/alu_b/alu_op=0, result reg=0, owner=0.
  - resp0/1_valid=0, resp0/1_c=0, busy=0.
- req*_ready is combinational: high only in IDLE and only for the granted requester.
- Grant in IDLE:
  - If only one valid, grant that requester.
  - If both valid, grant the requester indicated by prio.
  - If none valid, no grant and no ready.
- States:
  - IDLE: on accept, register a/b/op of the granted requester into alu_a/alu_b/alu_op, set owner=grant, go to EXEC.
  - EXEC: 1 cycle. alu_a/b/op are stable, alu_c is combinationally valid. Capture alu_c into result at the end of the cycle, go to RESP.
  - RESP: assert resp{owner}_valid=1 with resp{owner}_c=result. The other resp_valid stays 0. Hold valid and data stable until resp{owner}_ready=1. On that handshake: resp_valid drops next cycle, prio=~owner, go to IDLE.
- Latency and throughput:
  - Accept at cycle N -> resp_valid high at N+2.
  - With resp_ready already high, the next accept is possible at N+3.
  - Peak throughput is 1 op per 3 cycles.
- resp*_c is 0 when its resp*_valid is 0.
- alu_a/b/op hold their last values outside EXEC; they change only on accept.
- Requester contract: req_valid plus payload are held until ready, and are not dropped before ready. The arbiter samples the payload only on the accept cycle.
- resp_ready asserted while resp_valid=0 has no effect.
- Backpressure: RESP may last indefinitely. Requests arriving meanwhile see ready=0.
- Fairness: when both requesters stay continuously valid, grants alternate 0,1,0,1. Neither requester waits more than one foreign operation.
- Reset during EXEC or RESP: the operation is discarded, no response is ever produced, and after release the arbiter starts from IDLE with prio=0.
- Width rules: no extension or truncation; C is forwarded bit-exact.

Test Plan:
- Bench ALU model: op0=A+B, op1=A−B, op2=A&B.
- Single request: req0 A=5 B=7 op0 valid at N, resp0_ready=1 -> req0_ready=1 at N, alu_a=5 alu_b=7 during N+1, resp0_valid=1 resp0_c=12 at N+2, resp1_valid=0 throughout.
- Simultaneous after reset: req0 (A=10,B=3,op1) and req1 (A=0xF0,B=0x3C,op2) both valid -> req0 served first (resp0_c=7), then req1 (resp1_c=0x30), accepted 3 cycles apart.
- Fairness: both valid continuously for 6 ops -> grant order 0,1,0,1,0,1; each resp carries that requester's result.
- Backpressure: resp1_ready=0 for 5 cycles after resp1_valid -> resp1_valid and resp1_c (0xFFFFFFFF from A=0xFFFFFFFE,B=1,op0) held stable; req0_ready=0 meanwhile; req0 accepted the cycle after the resp1 handshake.
- Wrap-around: A=0xFFFFFFFF, B=1, op0 -> resp_c=0x00000000. A=0, B=1, op1 -> resp_c=0xFFFFFFFF.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 immediately, no resp_valid after release. The next simultaneous request pair serves req0 first.
